// File: rtl/timekeep_pkg.sv
// Shared encodings and field limits for the six-digit timekeeping core.
// Imported by the top level and by the field counters.
package timekeep_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SETUP = 2'd1,
        MODE_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    // Midnight shows as 12 and the afternoon folds back onto 1..11.
    function automatic logic [5:0] to_12h(input logic [5:0] hour);
        logic [5:0] shown;
        shown = hour;
        if (hour == 6'd0) begin
            shown = 6'd12;
        end else if (hour > 6'd12) begin
            shown = hour - 6'd12;
        end
        return shown;
    endfunction

endpackage

// File: rtl/hms_timekeeper_mod_cnt.sv
// Six-bit wrap counter for one time or alarm field; carry flags the wrap
// so the next field can advance on the same edge.
module mod_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic [5:0] max,
    output logic [5:0] value,
    output logic       carry
);

    logic at_max;

    assign at_max = (value == max);
    assign carry  = inc & at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 6'd0;
        end else if (inc) begin
            value <= at_max ? 6'd0 : value + 6'd1;
        end
    end

endmodule

// File: rtl/hms_timekeeper.sv
// Timekeeping core: tick divider, run/set/alarm mode control, alarm ring
// and display mux for the six-digit FND clock, all in the clk domain.
module hms_timekeeper
    import timekeep_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int ALARM_LEN = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode_pls,
    input  logic       i_pos_pls,
    input  logic       i_inc_pls,
    input  logic       i_fmt_12h,
    input  logic       i_alarm_en,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hour,
    output logic       o_pm,
    output logic [1:0] o_mode,
    output logic [1:0] o_position,
    output logic       o_tick,
    output logic       o_day_pls,
    output logic       o_alarm
);

    localparam int             DW        = $clog2(TICK_DIV);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [5:0]     RING_LOAD = 6'(ALARM_LEN);

    mode_t mode_q, mode_d;
    pos_t  pos_q, pos_d;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          is_setup;
    logic          setup_inc;
    logic          alarm_inc;

    logic [5:0] sec_val, min_val, hour_val;
    logic       sec_carry, min_carry, hour_carry;
    logic       sec_inc, min_inc, hour_inc;
    logic [5:0] alm_min_val, alm_hour_val;
    logic       alm_min_inc, alm_hour_inc;
    logic       alm_min_carry, alm_hour_carry;

    logic [5:0] min_next, hour_next;
    logic       trigger;
    logic       ring_stop;
    logic [5:0] ring_cnt;

    logic [5:0] disp_hour;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_CLOCK;
            pos_q  <= POS_SEC;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        if (i_mode_pls) begin
            case (mode_q)
                MODE_CLOCK: mode_d = MODE_SETUP;
                MODE_SETUP: mode_d = MODE_ALARM;
                default:    mode_d = MODE_CLOCK;
            endcase
        end
        if (i_pos_pls) begin
            case (pos_q)
                POS_SEC: pos_d = POS_MIN;
                POS_MIN: pos_d = POS_HOUR;
                default: pos_d = POS_SEC;
            endcase
        end
    end

    // Held at zero while setting so the first second after leaving SETUP is full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (mode_q == MODE_SETUP || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign is_setup  = (mode_q == MODE_SETUP);
    assign tick      = !is_setup && (div_cnt == DIV_LAST);
    assign setup_inc = is_setup & i_inc_pls;
    assign alarm_inc = (mode_q == MODE_ALARM) & i_inc_pls;

    // Carries only ripple while running; a manual set touches a single field.
    assign sec_inc  = tick | (setup_inc & (pos_q == POS_SEC));
    assign min_inc  = (sec_carry & ~is_setup) | (setup_inc & (pos_q == POS_MIN));
    assign hour_inc = (min_carry & ~is_setup) | (setup_inc & (pos_q == POS_HOUR));

    assign alm_min_inc  = alarm_inc & (pos_q == POS_MIN);
    assign alm_hour_inc = alarm_inc & (pos_q == POS_HOUR);

    mod_cnt u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .max   (SEC_MAX),
        .value (sec_val),
        .carry (sec_carry)
    );

    mod_cnt u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .max   (MIN_MAX),
        .value (min_val),
        .carry (min_carry)
    );

    mod_cnt u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hour_inc),
        .max   (HOUR_MAX),
        .value (hour_val),
        .carry (hour_carry)
    );

    mod_cnt u_alm_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (alm_min_inc),
        .max   (MIN_MAX),
        .value (alm_min_val),
        .carry (alm_min_carry)
    );

    mod_cnt u_alm_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (alm_hour_inc),
        .max   (HOUR_MAX),
        .value (alm_hour_val),
        .carry (alm_hour_carry)
    );

    assign o_day_pls = hour_carry & ~is_setup;

    // The alarm compares against the time this tick is about to produce.
    always_comb begin
        min_next  = min_val;
        hour_next = hour_val;
        if (min_carry) begin
            min_next = 6'd0;
        end else if (min_inc) begin
            min_next = min_val + 6'd1;
        end
        if (hour_carry) begin
            hour_next = 6'd0;
        end else if (hour_inc) begin
            hour_next = hour_val + 6'd1;
        end
    end

    assign trigger   = tick & sec_carry & i_alarm_en &
                       (min_next == alm_min_val) & (hour_next == alm_hour_val);
    assign ring_stop = (i_inc_pls & (mode_q == MODE_CLOCK)) | ~i_alarm_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_cnt <= 6'd0;
        end else if (ring_stop) begin
            ring_cnt <= 6'd0;
        end else if (trigger) begin
            ring_cnt <= RING_LOAD;
        end else if (tick && ring_cnt != 6'd0) begin
            ring_cnt <= ring_cnt - 6'd1;
        end
    end

    assign o_alarm = (ring_cnt != 6'd0);

    always_comb begin
        o_sec     = sec_val;
        o_min     = min_val;
        disp_hour = hour_val;
        if (mode_q == MODE_ALARM) begin
            o_sec     = 6'd0;
            o_min     = alm_min_val;
            disp_hour = alm_hour_val;
        end
        o_hour = i_fmt_12h ? to_12h(disp_hour) : disp_hour;
        o_pm   = (disp_hour >= 6'd12);
    end

    assign o_mode     = mode_q;
    assign o_position = pos_q;
    assign o_tick     = tick;

endmodule

// File: doc/hms_timekeeper.md
# hms_timekeeper

Single-clock-domain timekeeping core for the six-digit FND clock. It replaces the rippled per-field clocks with synchronous enables. It adds a three-mode controller (run / time-set / alarm-set), a 12/24-hour display format, an alarm with timed ring, and a parametrised tick divider. Inputs are already-debounced single-cycle pulses. Outputs are binary field values that feed the existing digit-split, segment-decode and LED-multiplex path.

## Interface
- TICK_DIV, 50_000_000: clk cycles per second tick; must be ≥2.
- ALARM_LEN, 30: ring duration in seconds; range 1..63.
- clk  in  1  system clock
- rst_n  in  1  reset: asynchronous, active-low
- i_mode_pls  in  1  one-cycle pulse; advances mode
- i_pos_pls  in  1  one-cycle pulse; advances edit position
- i_inc_pls  in  1  one-cycle pulse; increments the selected field, or stops the ring
- i_fmt_12h  in  1  level; 1 = 12-hour display
- i_alarm_en  in  1  level; alarm armed
- o_sec, o_min, o_hour  out  6 each  displayed field values
- o_pm  out  1  displayed hour ≥ 12
- o_mode  out  2  0 = CLOCK, 1 = SETUP, 2 = ALARM
- o_position  out  2  0 = SEC, 1 = MIN, 2 = HOUR
- o_tick  out  1  one-cycle pulse per second
- o_day_pls  out  1  one-cycle pulse on 23:59:59 → 00:00:00
- o_alarm  out  1  ring active

## Operation
- Reset values: time 00:00:00, alarm 00:00, mode CLOCK, position SEC, ring counter 0, tick counter 0. All outputs are 0 at reset.
- Tick divider: counter runs 0..TICK_DIV-1; o_tick is asserted on the cycle the counter equals TICK_DIV-1.
- In SETUP mode the divider is held at 0 and o_tick stays 0.
- Mode sequence on i_mode_pls: CLOCK → SETUP → ALARM → CLOCK. Position is retained across mode changes.
- Position sequence on i_pos_pls: SEC → MIN → HOUR → SEC.
- Run (CLOCK and ALARM modes): on o_tick, sec increments.
  - sec 59 wraps to 0 and increments min.
  - min 59 wraps to 0 and increments hour.
  - hour 23 wraps to 0.
  - All carries resolve in the same cycle.
  - o_day_pls fires on the full wrap.
- SETUP mode: time is frozen. i_inc_pls increments the selected time field modulo its maximum, with no carry into other fields.
- ALARM mode: time keeps running. i_inc_pls increments alarm min (mod 60) or alarm hour (mod 24); at position SEC it is ignored.
- Display mux:
  - ALARM mode shows the alarm fields, with o_sec = 0.
  - Other modes show the time fields.
- 12-hour format, when i_fmt_12h = 1:
  - hour 0 displays as 12.
  - hour 13..23 displays as hour-12.
  - o_pm = (internal hour ≥ 12) regardless of format.
- Alarm trigger: fires when a run tick makes the time equal alarm_hour:alarm_min:00 and i_alarm_en = 1. On trigger, o_alarm is set and the ring counter is loaded with ALARM_LEN.
  - Each subsequent tick decrements the ring counter.
  - o_alarm clears on the tick that decrements the counter to 0.
- Ring stop: o_alarm and the ring counter clear immediately on either of:
  - i_inc_pls while in CLOCK mode;
  - i_alarm_en low.
- Setting the time to match the alarm in SETUP mode never triggers it.

## Timing
- State registers update on the clk edge that samples the event. Display outputs are combinational from those registers, so they are valid in the next cycle.
- Simultaneous events:
  - i_inc_pls with i_mode_pls or i_pos_pls: the increment applies to the old mode and old position; the mode or position change takes effect on the same edge.
  - A tick together with i_inc_pls in ALARM mode: both are applied, since they target disjoint registers.
  - A tick together with a ring stop: the stop wins.
  - A retrigger while ringing reloads ALARM_LEN.
- Leaving SETUP: the divider restarts from 0, so the first second lasts the full TICK_DIV cycles.
- Mid-operation rst_n assertion returns everything to the reset values asynchronously. Release is synchronous to clk.

## Structure
- Package timekeep_pkg holds:
  - mode encodings MODE_CLOCK, MODE_SETUP, MODE_ALARM;
  - position encodings POS_SEC, POS_MIN, POS_HOUR;
  - constants SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
- Sub-module mod_cnt: 6-bit synchronous wrap counter with inputs inc and max, and a registered value plus a combinational carry output (carry = inc & value==max). It is instantiated for time sec, min and hour and for alarm min and hour.
- Divider width is $clog2(TICK_DIV). The ring counter is 6 bits.

## Test plan
All scenarios use TICK_DIV = 4 and ALARM_LEN = 3.
- Reset, run 240 cycles → 60 ticks total, o_sec 0..59 then 0, min = 1, o_tick period 4.
- Preload 23:59:58 via SETUP, return to CLOCK, run 2 ticks → 00:00:00 and one o_day_pls pulse.
- ALARM mode: set alarm 00:01, enable, run from 00:00:00 → o_alarm rises at 00:01:00 and falls 3 ticks later; a second run with i_inc_pls in CLOCK mode at 00:01:01 clears o_alarm next cycle.
- SETUP mode: position SEC at 59, then i_inc_pls → sec 0, min unchanged; same-cycle i_inc_pls + i_pos_pls → SEC incremented, position becomes MIN.
- i_fmt_12h = 1: hour 0 → 12, o_pm = 0; hour 13 → 1, o_pm = 1; hour 12 → 12, o_pm = 1.
- Assert rst_n mid-ring at 00:01:01 → all outputs 0 and mode CLOCK immediately; no ring after release.
